// File: rtl/sram_arb2_if.sv
// sram_arb2_if: bundles the two requester ports, the SRAM port and the
// statistics port of sram_arb2. The arbiter uses the slave modport; the
// requesters and the SRAM model use the master modport.
interface sram_arb2_if #(
  parameter int AW = 15,
  parameter int DW = 32
);
  // Requester A (APB bridge side)
  logic          a_req;
  logic          a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  // Requester B (DSP/DMA engine)
  logic          b_req;
  logic          b_wr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  // Shared single-port SRAM
  logic          sram_en;
  logic          sram_wr;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  // Statistics
  logic          stats_clr;
  logic [15:0]   a_wait_cnt;

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    input  sram_rdata, stats_clr,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output sram_en, sram_wr, sram_addr, sram_wdata,
    output a_wait_cnt
  );

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    output sram_rdata, stats_clr,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  sram_en, sram_wr, sram_addr, sram_wdata,
    input  a_wait_cnt
  );
endinterface

// File: rtl/sram_arb2.sv
// sram_arb2: shares one single-port SRAM between requester A (APB bridge)
// and requester B (DSP/DMA). B has fixed priority; a burst limiter hands A
// a slot after at most BURST_MAX consecutive B grants while A is waiting.
// Writes complete in the grant cycle; read data returns one cycle later,
// steered to the requester that owned the read.
// Optional feature: define SRAM_ARB_STATS_EN to add the A stall counter
// (a_wait_cnt, cleared by stats_clr). Without it a_wait_cnt is tied to 0.
module sram_arb2 #(
  parameter int AW        = 15,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4    // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  sram_arb2_if.slave  bus
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  logic [3:0] burst_cnt;
  logic       a_win;
  logic       b_win;
  logic       a_rd_pend;
  logic       b_rd_pend;

  // Grant decision; gated by reset so every output reads 0 while in reset.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (reset_n) begin
      if (bus.b_req && (!bus.a_req || (burst_cnt < BURST_LIM))) begin
        b_win = 1'b1;
      end else if (bus.a_req) begin
        a_win = 1'b1;
      end
    end
  end

  assign bus.a_gnt = a_win;
  assign bus.b_gnt = b_win;

  // SRAM command mux: winner's attributes pass through in the grant cycle.
  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wr    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (b_win) begin
      bus.sram_en    = 1'b1;
      bus.sram_wr    = bus.b_wr;
      bus.sram_addr  = bus.b_addr;
      bus.sram_wdata = bus.b_wdata;
    end else if (a_win) begin
      bus.sram_en    = 1'b1;
      bus.sram_wr    = bus.a_wr;
      bus.sram_addr  = bus.a_addr;
      bus.sram_wdata = bus.a_wdata;
    end
  end

  // Burst limiter: counts B grants taken while A waits, saturating at the limit.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (a_win || !bus.a_req) begin
      burst_cnt <= '0;
    end else if (b_win && (burst_cnt != BURST_LIM)) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

  // Read-owner tag: remembers who issued the read so the data returned next
  // cycle goes to the right requester. Reset drops any read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rd_pend <= 1'b0;
      b_rd_pend <= 1'b0;
    end else begin
      a_rd_pend <= a_win && !bus.a_wr;
      b_rd_pend <= b_win && !bus.b_wr;
    end
  end

  assign bus.a_rvalid = a_rd_pend;
  assign bus.b_rvalid = b_rd_pend;
  assign bus.a_rdata  = a_rd_pend ? bus.sram_rdata : '0;
  assign bus.b_rdata  = b_rd_pend ? bus.sram_rdata : '0;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] wait_cnt;

  // A stall counter: counts cycles A requests without a grant; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (bus.stats_clr) begin
      wait_cnt <= '0;
    end else if (bus.a_req && !a_win && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign bus.a_wait_cnt = wait_cnt;
`else
  logic unused_stats_clr;

  assign bus.a_wait_cnt   = '0;
  assign unused_stats_clr = bus.stats_clr;
`endif

endmodule
